// File: rtl/ext_int_ctrl.sv
// External interrupt controller: per-source level gateways (pending/in-service),
// max-priority arbitration with lowest-ID tie break, and a single-cycle register bus.
module ext_int_ctrl #(
  parameter int NUM_SRC   = 8,
  parameter int PRIO_W    = 3,
  parameter int INT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   src_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [7:0]           addr_i,
  input  logic [31:0]          wdata_i,
  output logic                 ack_o,
  output logic [31:0]          rdata_o,
  output logic [INT_WIDTH-1:0] int_flag_o,
  output logic [7:0]           int_id_o
);

  localparam logic [5:0] W_PENDING   = 6'd0;
  localparam logic [5:0] W_ENABLE    = 6'd1;
  localparam logic [5:0] W_THRESHOLD = 6'd2;
  localparam logic [5:0] W_CLAIM     = 6'd3;
  localparam int         W_PRIO_BASE = 4;

  logic [NUM_SRC-1:0] sync1;
  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] inservice;
  logic [NUM_SRC-1:0] enable;
  logic [PRIO_W-1:0]  threshold;
  logic [PRIO_W-1:0]  prio [NUM_SRC];
  logic [7:0]         win_id;
  logic [PRIO_W-1:0]  win_prio;
  logic               ack;
  logic [31:0]        rdata;

  logic [5:0]         word;
  logic               wr_en;
  logic               rd_en;
  logic               rd_claim;
  logic               wr_comp;
  logic [NUM_SRC-1:0] claim_vec;
  logic [NUM_SRC-1:0] comp_vec;
  logic [NUM_SRC-1:0] prio_we;
  logic [7:0]         nxt_id;
  logic [PRIO_W-1:0]  nxt_prio;
  logic [31:0]        rd_mux;
  logic               unused_bits;

  // Bus handshake: a request with req_i high at posedge E is always accepted;
  // ack_o is high for exactly the cycle after E, with rdata_o valid in that
  // cycle for reads and 0 otherwise. Write side effects land at E.
  assign word        = addr_i[7:2];
  assign wr_en       = req_i & we_i;
  assign rd_en       = req_i & ~we_i;
  assign rd_claim    = rd_en && (word == W_CLAIM) && (win_id != 8'd0);
  assign wr_comp     = wr_en && (word == W_CLAIM);
  assign unused_bits = ^{wdata_i[31:8], addr_i[1:0]};

  always_comb begin
    claim_vec = '0;
    comp_vec  = '0;
    prio_we   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_vec[i] = rd_claim && (win_id == 8'(i + 1));
      // IDs 0 and >NUM_SRC match no bit, so such completes fall away here.
      comp_vec[i]  = wr_comp && (wdata_i[7:0] == 8'(i + 1));
      prio_we[i]   = wr_en && (word == 6'(W_PRIO_BASE + i));
    end
  end

  // Strict '>' while scanning upward keeps the lowest ID on priority ties.
  always_comb begin
    nxt_id   = 8'd0;
    nxt_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending[i] && enable[i] && (prio[i] != '0) && (prio[i] > nxt_prio)) begin
        nxt_id   = 8'(i + 1);
        nxt_prio = prio[i];
      end
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (word)
      W_PENDING:   rd_mux = 32'(pending);
      W_ENABLE:    rd_mux = 32'(enable);
      W_THRESHOLD: rd_mux = 32'(threshold);
      W_CLAIM:     rd_mux = 32'(win_id);
      default: begin
        for (int k = 0; k < NUM_SRC; k++) begin
          if (word == 6'(W_PRIO_BASE + k)) rd_mux = 32'(prio[k]);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      src_s     <= '0;
      pending   <= '0;
      inservice <= '0;
      enable    <= '0;
      threshold <= '0;
      win_id    <= 8'd0;
      win_prio  <= '0;
      ack       <= 1'b0;
      rdata     <= 32'd0;
      for (int k = 0; k < NUM_SRC; k++) prio[k] <= '0;
    end else begin
      sync1 <= src_i;
      src_s <= sync1;
      // Claim beats a same-cycle set; a same-cycle complete still blocks the set
      // because the set looks at the in-service value before this edge.
      for (int i = 0; i < NUM_SRC; i++) begin
        if (claim_vec[i]) begin
          pending[i]   <= 1'b0;
          inservice[i] <= 1'b1;
        end else begin
          if (src_s[i] && !pending[i] && !inservice[i]) pending[i] <= 1'b1;
          if (comp_vec[i] && inservice[i]) inservice[i] <= 1'b0;
        end
      end
      if (wr_en && (word == W_ENABLE))    enable    <= wdata_i[NUM_SRC-1:0];
      if (wr_en && (word == W_THRESHOLD)) threshold <= wdata_i[PRIO_W-1:0];
      for (int k = 0; k < NUM_SRC; k++) begin
        if (prio_we[k]) prio[k] <= wdata_i[PRIO_W-1:0];
      end
      win_id   <= nxt_id;
      win_prio <= nxt_prio;
      ack      <= req_i;
      rdata    <= rd_en ? rd_mux : 32'd0;
    end
  end

  assign ack_o      = ack;
  assign rdata_o    = rdata;
  assign int_id_o   = win_id;
  assign int_flag_o = ((win_id != 8'd0) && (win_prio > threshold)) ? INT_WIDTH'(1) : '0;

endmodule
